avalon_clint: RTL and testbench

- Avalon-MM responder (slave) for the core's data-bus initiator.
- Provides a machine software-interrupt register, a 64-bit mtime counter with a prescaler, and a 64-bit mtimecmp comparator.
- Drives the core's software_interrupt and timer_interrupt inputs.
- Sits on the dbus interconnect behind the address decoder. The decoder delivers word addresses local to this block.

---
 rtl/avalon_clint.sv | 147 ++++++++++++++
 tb/tb_avalon_clint.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/avalon_clint.sv
// avalon_clint: Avalon-MM core-local interruptor with a machine software
// interrupt bit, a prescaled 64-bit mtime counter and a 64-bit mtimecmp
// comparator. Reads have a fixed one-cycle latency. A read of mtime_lo
// snapshots mtime_hi, so a lo-then-hi read pair gives a coherent 64-bit value.
module avalon_clint #(
  parameter int PRESCALE_W     = 16,
  parameter int RESET_PRESCALE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [2:0]  avs_address,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        avs_waitrequest,
  output logic        software_interrupt,
  output logic        timer_interrupt
);

  localparam logic [2:0] ADDR_MSIP      = 3'd0;
  localparam logic [2:0] ADDR_MTIME_LO  = 3'd1;
  localparam logic [2:0] ADDR_MTIME_HI  = 3'd2;
  localparam logic [2:0] ADDR_MTCMP_LO  = 3'd3;
  localparam logic [2:0] ADDR_MTCMP_HI  = 3'd4;
  localparam logic [2:0] ADDR_PRESCALE  = 3'd5;

  // Replace the bytes of cur selected by be with the matching bytes of wd.
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wd,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
    end
    return res;
  endfunction

  logic                  wait_q;
  logic                  msip_q, msip_nxt;
  logic [63:0]           mtime_q, mtime_nxt;
  logic [63:0]           mtcmp_q, mtcmp_nxt;
  logic [PRESCALE_W-1:0] prescale_q, prescale_nxt;
  logic [PRESCALE_W-1:0] cnt_q, cnt_nxt;
  logic [31:0]           shadow_q, shadow_nxt;
  logic                  irq_q;
  logic [31:0]           rdata_p1;
  logic                  vld_p1;

  logic                  wr_hit;
  logic                  rd_hit;
  logic                  tick;
  logic [31:0]           prescale_ext;
  logic [31:0]           prescale_wr;
  logic [31:0]           msip_wr;
  logic [31:0]           rd_mux;

  // A write with no byte lanes is a no-op, so it must not override the tick.
  // A read that collides with a write is dropped.
  assign wr_hit       = avs_write & ~wait_q & (|avs_byteenable);
  assign rd_hit       = avs_read & ~avs_write & ~wait_q;
  assign tick         = (cnt_q == prescale_q);
  assign prescale_ext = 32'(prescale_q);

  // Next-state for all architectural registers: tick first, then writes win.
  always_comb begin
    msip_nxt     = msip_q;
    mtime_nxt    = tick ? (mtime_q + 64'd1) : mtime_q;
    mtcmp_nxt    = mtcmp_q;
    prescale_nxt = prescale_q;
    cnt_nxt      = tick ? '0 : (cnt_q + PRESCALE_W'(1));
    shadow_nxt   = shadow_q;
    prescale_wr  = merge_bytes(prescale_ext, avs_writedata, avs_byteenable);
    msip_wr      = merge_bytes({31'd0, msip_q}, avs_writedata, avs_byteenable);
    if (wr_hit) begin
      case (avs_address)
        ADDR_MSIP:     msip_nxt = msip_wr[0];
        // The written half replaces the ticked value; the other half keeps
        // its pre-tick value, so no carry crosses into it.
        ADDR_MTIME_LO: mtime_nxt = {mtime_q[63:32],
                                    merge_bytes(mtime_q[31:0], avs_writedata, avs_byteenable)};
        ADDR_MTIME_HI: mtime_nxt = {merge_bytes(mtime_q[63:32], avs_writedata, avs_byteenable),
                                    mtime_q[31:0]};
        ADDR_MTCMP_LO: mtcmp_nxt[31:0]  = merge_bytes(mtcmp_q[31:0], avs_writedata, avs_byteenable);
        ADDR_MTCMP_HI: mtcmp_nxt[63:32] = merge_bytes(mtcmp_q[63:32], avs_writedata, avs_byteenable);
        ADDR_PRESCALE: begin
          prescale_nxt = prescale_wr[PRESCALE_W-1:0];
          cnt_nxt      = '0;
        end
        default: ;
      endcase
    end
    if (rd_hit && avs_address == ADDR_MTIME_LO) shadow_nxt = mtime_q[63:32];
  end

  // Read data selection from current register state; mtime_hi reads the shadow.
  always_comb begin
    rd_mux = 32'd0;
    case (avs_address)
      ADDR_MSIP:     rd_mux = {31'd0, msip_q};
      ADDR_MTIME_LO: rd_mux = mtime_q[31:0];
      ADDR_MTIME_HI: rd_mux = shadow_q;
      ADDR_MTCMP_LO: rd_mux = mtcmp_q[31:0];
      ADDR_MTCMP_HI: rd_mux = mtcmp_q[63:32];
      ADDR_PRESCALE: rd_mux = prescale_ext;
      default:       rd_mux = 32'd0;
    endcase
  end

  // Architectural state, compare flag and the one-cycle read response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q     <= 1'b1;
      msip_q     <= 1'b0;
      mtime_q    <= 64'd0;
      mtcmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
      prescale_q <= PRESCALE_W'(RESET_PRESCALE);
      cnt_q      <= '0;
      shadow_q   <= 32'd0;
      irq_q      <= 1'b0;
      rdata_p1   <= 32'd0;
      vld_p1     <= 1'b0;
    end else begin
      wait_q     <= 1'b0;
      msip_q     <= msip_nxt;
      mtime_q    <= mtime_nxt;
      mtcmp_q    <= mtcmp_nxt;
      prescale_q <= prescale_nxt;
      cnt_q      <= cnt_nxt;
      shadow_q   <= shadow_nxt;
      irq_q      <= (mtime_nxt >= mtcmp_nxt);
      // stage p1: read response, data held while no response is pending
      vld_p1     <= rd_hit;
      if (rd_hit) rdata_p1 <= rd_mux;
    end
  end

  assign avs_readdata       = rdata_p1;
  assign avs_readdatavalid  = vld_p1;
  assign avs_waitrequest    = wait_q;
  assign software_interrupt = msip_q;
  assign timer_interrupt    = irq_q;

endmodule

// File: tb/tb_avalon_clint.sv
// Directed bench for avalon_clint: register access, atomic mtime reads,
// prescaled counting, compare interrupt and reset behaviour.
module tb_avalon_clint;

  logic        clk;
  logic        rst;
  logic        avs_read;
  logic        avs_write;
  logic [2:0]  avs_address;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;
  logic        software_interrupt;
  logic        timer_interrupt;

  int n_checks = 0;
  int n_errors = 0;

  avalon_clint #(.PRESCALE_W(16), .RESET_PRESCALE(0)) dut (
    .clk               (clk),
    .rst               (rst),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_address       (avs_address),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_waitrequest   (avs_waitrequest),
    .software_interrupt(software_interrupt),
    .timer_interrupt   (timer_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = be;
    avs_write      = 1'b1;
    @(posedge clk);
    #1;
    avs_write      = 1'b0;
    avs_byteenable = 4'b0000;
  endtask

  task automatic rd(input logic [2:0] a, input string tag, input logic [31:0] exp);
    avs_address = a;
    avs_read    = 1'b1;
    @(posedge clk);
    #1;
    avs_read    = 1'b0;
    check({tag, "_vld"}, {31'd0, avs_readdatavalid}, 32'd1);
    check(tag, avs_readdata, exp);
  endtask

  logic [31:0] tick_exp [8] = '{32'd10, 32'd10, 32'd11, 32'd11,
                                32'd11, 32'd11, 32'd12, 32'd12};

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_address    = 3'd0;
    avs_writedata  = 32'd0;
    avs_byteenable = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wait", {31'd0, avs_waitrequest}, 32'd1);
    check("rst_vld",  {31'd0, avs_readdatavalid}, 32'd0);
    check("rst_data", avs_readdata, 32'd0);
    check("rst_swi",  {31'd0, software_interrupt}, 32'd0);
    check("rst_tmr",  {31'd0, timer_interrupt}, 32'd0);

    // release with a read already pending: first edge must not accept it
    rst         = 1'b1;
    avs_read    = 1'b1;
    avs_address = 3'd3;
    #1;
    check("wait_first", {31'd0, avs_waitrequest}, 32'd1);
    @(posedge clk); #1;
    check("wait_drop", {31'd0, avs_waitrequest}, 32'd0);
    check("wait_noacc", {31'd0, avs_readdatavalid}, 32'd0);
    @(posedge clk); #1;
    check("cmp_lo_vld", {31'd0, avs_readdatavalid}, 32'd1);
    check("cmp_lo_rst", avs_readdata, 32'hFFFF_FFFF);
    avs_address = 3'd4;
    @(posedge clk); #1;
    avs_read = 1'b0;
    check("cmp_hi_vld", {31'd0, avs_readdatavalid}, 32'd1);
    check("cmp_hi_rst", avs_readdata, 32'hFFFF_FFFF);
    check("t1_tmr", {31'd0, timer_interrupt}, 32'd0);

    // carry into the high word seen through the shadow
    wr(3'd1, 32'hFFFF_FFFE, 4'hF);
    wr(3'd2, 32'd0, 4'hF);
    idle(2);
    rd(3'd1, "wrap_lo", 32'd0);
    rd(3'd2, "wrap_hi", 32'd1);

    // prescale 3: one tick every four cycles
    wr(3'd5, 32'd3, 4'hF);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd2, 32'd0, 4'hF);
    idle(40);
    avs_address = 3'd1;
    avs_read    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("tick_vld", {31'd0, avs_readdatavalid}, 32'd1);
      check($sformatf("tick_%0d", i), avs_readdata, tick_exp[i]);
    end
    avs_read = 1'b0;

    // compare interrupt rise and fall
    wr(3'd5, 32'd0, 4'hF);
    wr(3'd2, 32'd0, 4'hF);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd4, 32'd0, 4'hF);
    wr(3'd3, 32'd20, 4'hF);
    idle(17);
    check("tmr_before", {31'd0, timer_interrupt}, 32'd0);
    idle(1);
    check("tmr_rise", {31'd0, timer_interrupt}, 32'd1);
    rd(3'd1, "tmr_mtime", 32'd20);
    check("tmr_hold", {31'd0, timer_interrupt}, 32'd1);
    wr(3'd3, 32'd100, 4'hF);
    check("tmr_fall", {31'd0, timer_interrupt}, 32'd0);

    // msip byte enables and unmapped address
    wr(3'd0, 32'd1, 4'b0000);
    check("swi_be0", {31'd0, software_interrupt}, 32'd0);
    wr(3'd0, 32'd1, 4'b0001);
    check("swi_set", {31'd0, software_interrupt}, 32'd1);
    rd(3'd0, "msip_rd", 32'd1);
    wr(3'd7, 32'hFFFF_FFFF, 4'hF);
    rd(3'd7, "unmapped", 32'd0);

    // back-to-back reads with a frozen counter
    wr(3'd5, 32'h0000_FFFF, 4'hF);
    wr(3'd1, 32'h1234_5678, 4'hF);
    wr(3'd2, 32'h0000_ABCD, 4'hF);
    avs_read    = 1'b1;
    avs_address = 3'd1;
    @(posedge clk); #1;
    check("b2b0_vld", {31'd0, avs_readdatavalid}, 32'd1);
    check("b2b0", avs_readdata, 32'h1234_5678);
    avs_address = 3'd2;
    @(posedge clk); #1;
    check("b2b1_vld", {31'd0, avs_readdatavalid}, 32'd1);
    check("b2b1", avs_readdata, 32'h0000_ABCD);
    avs_address = 3'd5;
    @(posedge clk); #1;
    avs_read = 1'b0;
    check("b2b2_vld", {31'd0, avs_readdatavalid}, 32'd1);
    check("b2b2", avs_readdata, 32'h0000_FFFF);
    @(posedge clk); #1;
    check("b2b_end", {31'd0, avs_readdatavalid}, 32'd0);

    // read and write together: write wins, no response
    avs_read       = 1'b1;
    avs_write      = 1'b1;
    avs_address    = 3'd0;
    avs_writedata  = 32'd0;
    avs_byteenable = 4'b0001;
    @(posedge clk); #1;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_byteenable = 4'b0000;
    check("rw_vld", {31'd0, avs_readdatavalid}, 32'd0);
    check("rw_swi", {31'd0, software_interrupt}, 32'd0);
    check("rw_hold", avs_readdata, 32'h0000_FFFF);
    check("big_tmr", {31'd0, timer_interrupt}, 32'd1);

    // asynchronous reset drops a pending response immediately
    avs_read    = 1'b1;
    avs_address = 3'd5;
    @(posedge clk); #1;
    avs_read = 1'b0;
    check("pre_rst_vld", {31'd0, avs_readdatavalid}, 32'd1);
    rst = 1'b0;
    #1;
    check("arst_vld", {31'd0, avs_readdatavalid}, 32'd0);
    check("arst_wait", {31'd0, avs_waitrequest}, 32'd1);
    check("arst_data", avs_readdata, 32'd0);
    check("arst_tmr", {31'd0, timer_interrupt}, 32'd0);
    rst = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
